// File: rtl/ddr_app_responder.sv
// rtl/ddr_app_responder.sv - RAM-backed responder for the DDR3 app_* user interface
module ddr_app_responder #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 128,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LATENCY   = 4,
  parameter int STALL_EN     = 0
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              init_calib_complete,
  input  logic [5:0]        app_burst_number,
  input  logic [27:0]       app_addr,
  input  logic              app_cmd_en,
  input  logic [2:0]        app_cmd,
  output logic              app_cmd_rdy,
  input  logic              app_wdata_en,
  input  logic              app_wdata_end,
  input  logic [DATA_W-1:0] app_wdata,
  output logic              app_wdata_rdy,
  output logic              app_rdata_valid,
  output logic              app_rdata_end,
  output logic [DATA_W-1:0] app_rdata,
  output logic              proto_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam int WW    = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_CALIB,
    S_IDLE,
    S_WRITE,
    S_RD_WAIT,
    S_READ
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [CW-1:0]     calib_cnt;
  logic [WW-1:0]     wait_cnt;
  logic [ADDR_W-1:0] base;
  logic [5:0]        len_m1;
  logic [6:0]        k;
  logic [15:0]       lfsr;

  logic              cmd_accept;
  logic              wr_en;
  logic              rd_issue;
  logic              err_set;
  logic [ADDR_W-1:0] addr_k;
  logic [ADDR_W-1:0] wr_idx;

  // upper address bits are don't-care for this RAM depth
  logic unused_addr_bits;
  assign unused_addr_bits = ^app_addr[27:ADDR_W];

  // burst position wraps silently within the RAM
  assign addr_k = base + ADDR_W'(k);

  // next-state, handshake readies and per-cycle action strobes
  always_comb begin
    state_next    = state;
    app_cmd_rdy   = 1'b0;
    app_wdata_rdy = 1'b0;
    cmd_accept    = 1'b0;
    wr_en         = 1'b0;
    rd_issue      = 1'b0;
    err_set       = 1'b0;
    wr_idx        = addr_k;
    case (state)
      S_CALIB: begin
        if (calib_cnt == CALIB_LAST) state_next = S_IDLE;
      end
      S_IDLE: begin
        app_cmd_rdy   = 1'b1;
        app_wdata_rdy = 1'b1;
        if (app_cmd_en && app_cmd == 3'd0) begin
          cmd_accept = 1'b1;
          if (app_wdata_en) begin
            // beat 0 may ride along with the write command
            wr_en      = 1'b1;
            wr_idx     = app_addr[ADDR_W-1:0];
            state_next = (app_burst_number == 6'd0) ? S_IDLE : S_WRITE;
          end else begin
            state_next = S_WRITE;
          end
        end else begin
          if (app_cmd_en && app_cmd == 3'd1) begin
            cmd_accept = 1'b1;
            state_next = S_RD_WAIT;
          end else if (app_cmd_en) begin
            err_set = 1'b1;
          end
          // a data beat with no write command to own it is dropped
          if (app_wdata_en) err_set = 1'b1;
        end
      end
      S_WRITE: begin
        app_wdata_rdy = !(STALL_EN != 0 && lfsr[1:0] == 2'b00);
        if (app_wdata_en && app_wdata_rdy) begin
          wr_en = 1'b1;
          if (k[5:0] == len_m1) state_next = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          rd_issue   = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ: begin
        // stay one cycle past the last beat so valid drops before IDLE
        if (k == {1'b0, len_m1} + 7'd1) state_next = S_IDLE;
        else rd_issue = 1'b1;
      end
      default: state_next = S_CALIB;
    endcase
    if (wr_en && !app_wdata_end) err_set = 1'b1;
  end

  // state register, counters, burst context and registered read port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state               <= S_CALIB;
      calib_cnt           <= '0;
      wait_cnt            <= '0;
      init_calib_complete <= 1'b0;
      proto_err           <= 1'b0;
      base                <= '0;
      len_m1              <= '0;
      k                   <= '0;
      lfsr                <= 16'hACE1;
      app_rdata_valid     <= 1'b0;
      app_rdata_end       <= 1'b0;
      app_rdata           <= '0;
    end else begin
      state <= state_next;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (state == S_CALIB && state_next == S_CALIB) calib_cnt <= calib_cnt + CW'(1);
      if (state == S_CALIB && state_next == S_IDLE) init_calib_complete <= 1'b1;
      if (err_set) proto_err <= 1'b1;
      wait_cnt <= (state == S_RD_WAIT) ? wait_cnt + WW'(1) : '0;
      if (cmd_accept) begin
        base   <= app_addr[ADDR_W-1:0];
        len_m1 <= app_burst_number;
        k      <= {6'd0, wr_en};
      end else if (wr_en || rd_issue) begin
        k <= k + 7'd1;
      end
      app_rdata_valid <= rd_issue;
      app_rdata_end   <= rd_issue;
      if (rd_issue) app_rdata <= mem[addr_k];
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem[wr_idx] <= app_wdata;
  end

endmodule
